// File: rtl/plate_row_locator.sv
// plate_row_locator: finds the longest run of high-transition rows in a binarized frame; ROW_STATS_EN adds per-row transition debug outputs
module plate_row_locator #(
  parameter int IMG_W        = 320,
  parameter int IMG_H        = 240,
  parameter int TRANS_THRESH = 20,
  parameter int MIN_BAND     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [11:0] pix_in,
  output logic        pix_ready,
  output logic        band_valid,
  output logic        band_found,
  output logic [7:0]  band_top,
  output logic [7:0]  band_bottom,
  output logic [8:0]  row_trans,
  output logic        row_stat_valid
);
  localparam logic [8:0] W_LAST = 9'(IMG_W - 1);
  localparam logic [8:0] THR    = 9'(TRANS_THRESH);
  localparam logic [7:0] H_LAST = 8'(IMG_H - 1);
  localparam logic [7:0] MINB   = 8'(MIN_BAND);
  typedef enum logic [1:0] {IDLE, ROW, ROW_END, DONE} state_t;
  state_t     state_q;
  logic [8:0] col_q, trans_q, trans_d;
  logic [7:0] row_q, run_len_q, run_start_q, best_len_q, best_top_q;
  logic [7:0] run_len_d, run_start_d, close_len;
  logic [7:0] band_top_q, band_bottom_q;
  logic       prev_b_q, band_valid_q, band_found_q;
  logic       b, accept, row_done, cand, better;
  logic       unused_bits;
  assign unused_bits = ^pix_in[10:0];
  // row evaluation and run bookkeeping; a run still open on the last row closes including that row
  always_comb begin
    b           = pix_in[11];
    accept      = pix_valid && (state_q == ROW || frame_start);
    trans_d     = (col_q != 9'd0 && b != prev_b_q && trans_q != 9'h1FF) ? trans_q + 9'd1 : trans_q;
    row_done    = state_q == ROW && pix_valid && !frame_start && col_q == W_LAST;
    cand        = trans_q >= THR;
    run_len_d   = cand ? run_len_q + 8'd1 : 8'd0;
    run_start_d = (cand && run_len_q == 8'd0) ? row_q : run_start_q;
    close_len   = cand ? run_len_d : run_len_q;
    better      = (!cand || row_q == H_LAST) && close_len >= MINB && close_len > best_len_q;
  end
  // frame FSM with registered band results; frame_start restarts from any state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      trans_q       <= '0;
      row_q         <= '0;
      run_len_q     <= '0;
      run_start_q   <= '0;
      best_len_q    <= '0;
      best_top_q    <= '0;
      prev_b_q      <= 1'b0;
      band_valid_q  <= 1'b0;
      band_found_q  <= 1'b0;
      band_top_q    <= '0;
      band_bottom_q <= '0;
    end else if (frame_start) begin
      state_q      <= ROW;
      col_q        <= accept ? 9'd1 : 9'd0;
      trans_q      <= '0;
      row_q        <= '0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_top_q   <= '0;
      prev_b_q     <= accept ? b : prev_b_q;
      band_valid_q <= 1'b0;
    end else begin
      band_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: ;
        ROW: if (pix_valid) begin
          prev_b_q <= b;
          trans_q  <= trans_d;
          col_q    <= row_done ? 9'd0 : col_q + 9'd1;
          state_q  <= row_done ? ROW_END : ROW;
        end
        ROW_END: begin
          run_len_q   <= run_len_d;
          run_start_q <= run_start_d;
          trans_q     <= '0;
          best_len_q  <= better ? close_len : best_len_q;
          best_top_q  <= better ? run_start_d : best_top_q;
          row_q       <= row_q == H_LAST ? row_q : row_q + 8'd1;
          state_q     <= row_q == H_LAST ? DONE : ROW;
        end
        DONE: begin
          band_valid_q  <= 1'b1;
          band_found_q  <= best_len_q != 8'd0;
          band_top_q    <= best_len_q != 8'd0 ? best_top_q : 8'd0;
          band_bottom_q <= best_len_q != 8'd0 ? best_top_q + best_len_q - 8'd1 : 8'd0;
          state_q       <= IDLE;
        end
      endcase
    end
  end
  assign pix_ready   = state_q == ROW;
  assign band_valid  = band_valid_q;
  assign band_found  = band_found_q;
  assign band_top    = band_top_q;
  assign band_bottom = band_bottom_q;
`ifdef ROW_STATS_EN
  logic [8:0] row_trans_q;
  logic       row_stat_valid_q;
  // capture each row's final transition count so it is visible during ROW_END
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_trans_q      <= '0;
      row_stat_valid_q <= 1'b0;
    end else begin
      row_stat_valid_q <= row_done;
      row_trans_q      <= row_done ? trans_d : row_trans_q;
    end
  end
  assign row_trans      = row_trans_q;
  assign row_stat_valid = row_stat_valid_q;
`else
  assign row_trans      = '0;
  assign row_stat_valid = 1'b0;
`endif
endmodule

// File: tb/tb_plate_row_locator.sv
// tb_plate_row_locator: directed frames on a 16x12 image checking band results, timing, abort and reset
`timescale 1ns/1ps
module tb_plate_row_locator;
  logic        clk = 1'b0, rst = 1'b0, frame_start = 1'b0, pix_valid = 1'b0;
  logic [11:0] pix_in = '0;
  logic        pix_ready, band_valid, band_found, row_stat_valid;
  logic [7:0]  band_top, band_bottom;
  logic [8:0]  row_trans;
  logic [15:0] pat [12];
  logic [8:0]  rt_obs [16];
  logic        rsv_obs [16];
  int tests = 0, fails = 0, bv_cnt = 0, c0;
`ifdef ROW_STATS_EN
  localparam int RT5 = 4, RT4 = 3, RSV = 1;
`else
  localparam int RT5 = 0, RT4 = 0, RSV = 0;
`endif

  plate_row_locator #(.IMG_W(16), .IMG_H(12), .TRANS_THRESH(4), .MIN_BAND(2)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .band_valid(band_valid), .band_found(band_found),
    .band_top(band_top), .band_bottom(band_bottom), .row_trans(row_trans), .row_stat_valid(row_stat_valid));

  always #5 clk = ~clk;
  always @(negedge clk) bv_cnt += int'(band_valid === 1'b1);
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pixv(input int i);
    return pat[i / 16][i % 16] ? 12'hFFF : 12'h000;
  endfunction

  task automatic fill(input logic [15:0] v);
    for (int r = 0; r < 12; r++) pat[r] = v;
  endtask

  // first pixel rides with frame_start; while not ready a conflicting pixel is presented and must be dropped
  task automatic drive(input int n);
    int idx, guard, rend;
    logic rdy;
    @(negedge clk);
    frame_start = 1'b1;
    pix_valid = 1'b1;
    pix_in = pixv(0);
    @(posedge clk);
    idx = 1;
    rend = 0;
    guard = 0;
    while (idx < n && guard < 1000) begin
      @(negedge clk);
      frame_start = 1'b0;
      rdy = pix_ready;
      if (rdy) pix_in = pixv(idx);
      else begin
        pix_in = ~pixv(idx);
        if (rend < 16) begin
          rt_obs[rend] = row_trans;
          rsv_obs[rend] = row_stat_valid;
        end
        rend++;
      end
      @(posedge clk);
      if (rdy) idx++;
      guard++;
    end
    if (idx < n) chk("drive_timeout", idx, n);
  endtask

  task automatic wait_band(input string tag, input logic ef, input logic [7:0] et, input logic [7:0] eb);
    int lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
      pix_valid = 1'b0;
      if (band_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_found"}, band_found, ef);
    chk({tag, "_top"}, band_top, et);
    chk({tag, "_bottom"}, band_bottom, eb);
    @(negedge clk);
    chk({tag, "_pulse_end"}, band_valid, 0);
    chk({tag, "_idle_ready"}, pix_ready, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", pix_ready, 0);
    chk("rst_bvalid", band_valid, 0);
    chk("rst_found", band_found, 0);
    chk("rst_top", band_top, 0);
    chk("rst_bottom", band_bottom, 0);
    chk("rst_rtrans", row_trans, 0);
    chk("rst_rsv", row_stat_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pix_in = i[0] ? 12'hFFF : 12'h000;
      @(negedge clk);
      chk("idle_ignores", pix_ready, 0);
    end
    pix_valid = 1'b0;
    // band at rows 3-6
    fill(16'h0000);
    for (int r = 3; r <= 6; r++) pat[r] = 16'h5555;
    c0 = bv_cnt;
    drive(192);
    wait_band("s1", 1, 3, 6);
    chk("s1_rsv_row0", rsv_obs[0], RSV);
    chk("s1_rt_row3", rt_obs[3], RSV ? 15 : 0);
    chk("s1_one_pulse", bv_cnt, c0 + 1);
    // no candidate rows
    fill(16'hFFFF);
    drive(192);
    wait_band("s2", 0, 0, 0);
    // equal-length runs keep the earlier one
    fill(16'h0000);
    pat[1] = 16'h5555; pat[2] = 16'h5555; pat[7] = 16'h5555; pat[8] = 16'h5555;
    drive(192);
    wait_band("s3_tie", 1, 1, 2);
    pat[9] = 16'h5555;
    drive(192);
    wait_band("s3_longer", 1, 7, 9);
    // lone candidate row with exactly threshold transitions
    fill(16'h0F0F);
    pat[5] = 16'h0F0E;
    drive(192);
    wait_band("s4", 0, 0, 0);
    chk("s4_rt_row5", rt_obs[5], RT5);
    chk("s4_rsv_row5", rsv_obs[5], RSV);
    chk("s4_rt_row4", rt_obs[4], RT4);
    // abort mid row 4, new frame has a same-length band later
    fill(16'h0000);
    pat[1] = 16'h5555; pat[2] = 16'h5555; pat[3] = 16'h5555;
    c0 = bv_cnt;
    drive(72);
    fill(16'h0000);
    pat[8] = 16'h5555; pat[9] = 16'h5555;
    drive(192);
    wait_band("s5", 1, 8, 9);
    chk("s5_one_pulse", bv_cnt, c0 + 1);
    // reset mid-frame, then a band touching the last row
    fill(16'h5555);
    drive(40);
    @(negedge clk);
    rst = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("s6_ready", pix_ready, 0);
    chk("s6_found", band_found, 0);
    chk("s6_top", band_top, 0);
    chk("s6_bottom", band_bottom, 0);
    chk("s6_rtrans", row_trans, 0);
    rst = 1'b1;
    fill(16'h0000);
    pat[10] = 16'h5555; pat[11] = 16'h5555;
    drive(192);
    wait_band("s6", 1, 10, 11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/plate_row_locator.md
# plate_row_locator

- Locates the candidate licence-plate band in a binarized frame by counting black/white transitions per row and reporting the longest run of high-transition rows.
- Sits directly downstream of the binarization stage: it consumes its 12-bit binary pixel stream, one pixel per accepted cycle, raster order.
- Outputs the band's top and bottom row once per frame to the character-segmentation logic.

## Interface
- IMG_W, 320: pixels per row.
- IMG_H, 240: rows per frame.
- TRANS_THRESH, 20: minimum transitions for a row to be a candidate.
- MIN_BAND, 8: minimum consecutive candidate rows to qualify as a band.
- clk  in  1: single clock, all logic on rising edge.
- rst  in  1: synchronous, active-low reset.
- frame_start  in  1: one-cycle pulse marking start of frame.
- pix_valid  in  1: pix_in is valid this cycle.
- pix_in  in  12: binarized pixel, 12'h000 or 12'hFFF; only bit 11 is used.
- pix_ready  out  1: block accepts a pixel this cycle when pix_valid && pix_ready.
- band_valid  out  1: one-cycle pulse, band outputs are updated.
- band_found  out  1: a qualifying band existed in the last frame.
- band_top  out  8: first row of band.
- band_bottom  out  8: last row of band.
- row_trans  out  9: transition count of the just-finished row (debug, see Configuration).
- row_stat_valid  out  1: one-cycle pulse with row_trans.

## Operation
- States:
  - IDLE: waiting for a frame.
  - ROW: accepting pixels.
  - ROW_END: one-cycle row evaluation.
  - DONE: one-cycle result publish.
- Reset (rst low at an edge):
  - state=IDLE, all counters 0, pix_ready=0, band_valid=0.
  - band_found=0, band_top=0, band_bottom=0, row_trans=0, row_stat_valid=0.
- frame_start in any state:
  - col=0, row=0, trans=0, run_len=0, best_len=0, best_top=0; next state ROW.
  - An in-progress frame is abandoned with no band_valid.
- ROW:
  - pix_ready=1.
  - Per accepted pixel, b=pix_in[11]. If col!=0 and b!=prev_b, trans++, saturating at 511. prev_b<=b, col++.
  - When the pixel at col==IMG_W-1 is accepted: col<=0, next state ROW_END.
- ROW_END:
  - pix_ready=0; cand = (trans >= TRANS_THRESH).
  - If cand: run_start<=row when run_len==0, run_len++.
  - Otherwise close the run (below), then run_len<=0.
  - trans<=0. If row==IMG_H-1, close the run and go to DONE; else row++ and go to ROW.
- Close run: if run_len >= MIN_BAND and run_len > best_len, then best_len<=run_len and best_top<=run_start. Ties keep the earlier band.
- DONE:
  - band_valid=1 and band_found=(best_len!=0).
  - band_top=best_top and band_bottom=best_top+best_len-1, or both 0 when none found.
  - Next state IDLE. Band outputs hold until the next DONE or reset.
- IDLE: pix_ready=0; pixels are ignored.
- Arithmetic: row and run registers are 8 bits; col and trans are 9 bits; comparisons are unsigned.

## Timing
- Pixel throughput: one pixel per cycle in ROW, so each row takes IMG_W+1 cycles including ROW_END.
- frame_start and pix_valid in the same cycle: that pixel is accepted as col 0 of row 0 of the new frame. pix_ready is treated as 1 in that cycle.
- Last pixel of a row accepted at edge N: ROW_END spans the cycle after N; row_stat_valid is high in that cycle.
- Last pixel of the frame accepted at edge N: band_valid is high in the cycle starting at edge N+2.
- rst low overrides frame_start.
- pix_valid while pix_ready=0: the pixel is dropped; upstream must hold or repeat it.

## Configuration
- ROW_STATS_EN defined:
  - row_trans drives the final trans of each row during ROW_END and holds it otherwise.
  - row_stat_valid pulses in each ROW_END.
- ROW_STATS_EN undefined:
  - row_trans and row_stat_valid are tied 0 and the debug registers are removed.
  - Band behaviour is identical.

## Test plan
All scenarios use IMG_W=16, IMG_H=12, TRANS_THRESH=4, MIN_BAND=2.
- Rows 3–6 alternate pixels (15 transitions), all other rows solid 0 -> band_valid once, band_found=1, top=3, bottom=6.
- All rows solid 12'hFFF -> band_found=0, top=0, bottom=0, band_valid still pulses.
- Candidate runs at rows 1–2 and 7–8 (equal length) -> top=1, bottom=2. Adding row 9 as a candidate -> top=7, bottom=9.
- Single candidate row 5 and 3-transition rows elsewhere -> band_found=0.
- frame_start reasserted mid-row 4 of a frame containing a band -> no band_valid for the aborted frame; new frame result only.
- rst low during ROW, then a full frame -> all outputs 0 after reset; correct band for the subsequent frame.
- With ROW_STATS_EN, a row with exactly 4 transitions -> row_trans=4 with row_stat_valid.
- pix_valid held high through ROW_END -> that pixel is not counted.
